// File: rtl/piso_tx_if.sv
// Parallel-in / serial-out link bundle for piso_tx_ctrl.
// Handshake: a word transfers on any rising edge where s_valid && s_ready are both
// high. s_ready depends only on the holding register being empty, never on s_valid.
// The producer keeps s_data stable while s_valid is high and the word has not
// transferred yet. flush is a side-band abort and takes no part in the handshake.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             flush;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             sout;
    logic             sout_valid;
    logic             first;
    logic             last;
    logic             done;
    logic             busy;

    // Producer / link side: drives the word and flush, observes the serial stream.
    modport master (
        output flush, s_valid, s_data,
        input  s_ready, sout, sout_valid, first, last, done, busy
    );

    // Serializer side.
    modport slave (
        input  flush, s_valid, s_data,
        output s_ready, sout, sout_valid, first, last, done, busy
    );
endinterface

// File: rtl/piso_tx_ctrl.sv
// Sequencer for a left-shifting PISO serializer: one-word holding register,
// MSB-first shift-out with first/last/done strobes and a configurable idle gap
// between consecutive words.
module piso_tx_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    piso_tx_if.slave    bus,
    output logic [1:0]  dbg_state
);
    localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             done_q;

    // Holding register, shift register, counters and the state machine in one block.
    // Accepts only happen with the hold empty, reloads only with it full, so the two
    // never compete for hold_full on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            done_q    <= 1'b0;
        end else if (bus.flush) begin
            // Abort drops both the held word and the one on the wire; an offer on
            // this edge is deliberately ignored.
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.s_valid && !hold_full) begin
                hold      <= bus.s_data;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shreg     <= hold;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
                        done_q  <= 1'b1;
                        bit_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else if (hold_full) begin
                            // No gap: next word follows the LSB directly.
                            shreg     <= hold;
                            hold_full <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_END) begin
                        gap_cnt <= '0;
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Serial outputs and strobes are plain decodes of registered state.
    assign bus.sout_valid = (state == SHIFT);
    assign bus.sout       = bus.sout_valid & shreg[WIDTH-1];
    assign bus.first      = bus.sout_valid && (bit_cnt == '0);
    assign bus.last       = bus.sout_valid && (bit_cnt == BIT_LAST);
    assign bus.done       = done_q;
    assign bus.busy       = (state != IDLE) || hold_full;
    assign bus.s_ready    = !hold_full;
    assign dbg_state      = state;
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: two instances (GAP_CYCLES=1 and GAP_CYCLES=0) share one
// stimulus stream and are compared every cycle with a word-timeline reference model;
// instance 0 also feeds a word scoreboard rebuilt from the serial stream.
module tb_piso_tx_ctrl;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state0;
    logic [1:0] dbg_state1;

    piso_tx_if #(.WIDTH(W)) if0 ();
    piso_tx_if #(.WIDTH(W)) if1 ();

    piso_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(1)) u_dut_g1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if0.slave),
        .dbg_state (dbg_state0)
    );

    piso_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) u_dut_g0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if1.slave),
        .dbg_state (dbg_state1)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    // Reference model: per instance, the held word and the most recently started
    // word with the cycle its MSB appears. Everything else follows from arithmetic:
    // a word occupies WIDTH bit cycles then GAP cycles, done lands at start+WIDTH.
    int             gaps [2] = '{1, 0};
    logic           hv   [2];
    logic [W-1:0]   hd   [2];
    logic           cv   [2];
    logic [W-1:0]   cd   [2];
    int             cs   [2];
    int             pdone[2];
    logic           acc0;

    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   rx_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model across one clock edge with the inputs sampled at that edge.
    task automatic model_edge(input logic r, input logic f, input logic v, input logic [W-1:0] d);
        cyc++;
        acc0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!r || f) begin
                hv[k]    = 1'b0;
                cv[k]    = 1'b0;
                pdone[k] = -1;
            end else if (hv[k]) begin
                if (!cv[k] || cyc >= cs[k] + W + gaps[k]) begin
                    pdone[k] = cv[k] ? cs[k] + W : -1;
                    cd[k]    = hd[k];
                    cs[k]    = cyc;
                    cv[k]    = 1'b1;
                    hv[k]    = 1'b0;
                end
            end else if (v) begin
                hd[k] = d;
                hv[k] = 1'b1;
                if (k == 0) begin
                    acc0 = 1'b1;
                    exp_q.push_back(d);
                end
            end
        end
        if (!r || f) begin
            exp_q.delete();
            rx_acc = '0;
        end
    endtask

    // Expected {s_ready, sout, sout_valid, first, last, done, busy} for the current cycle.
    function automatic logic [6:0] exp_vec(input int k);
        int   off;
        logic in_bits;
        logic sbit;
        logic dn;
        logic bz;
        off     = cyc - cs[k];
        in_bits = cv[k] && off >= 0 && off < W;
        sbit    = in_bits ? cd[k][W-1-off] : 1'b0;
        dn      = (cv[k] && off == W) || (pdone[k] == cyc);
        bz      = hv[k] || (cv[k] && off >= 0 && off < W + gaps[k]);
        return {!hv[k], sbit, in_bits, in_bits && off == 0, in_bits && off == W - 1, dn, bz};
    endfunction

    // Driver: one clock with the given inputs, then compare both instances.
    task automatic step(input logic r, input logic f, input logic v, input logic [W-1:0] d);
        rst         = r;
        if0.flush   = f;
        if0.s_valid = v;
        if0.s_data  = d;
        if1.flush   = f;
        if1.s_valid = v;
        if1.s_data  = d;
        @(posedge clk);
        model_edge(r, f, v, d);
        #1;
        check("outs_gap1", 32'({if0.s_ready, if0.sout, if0.sout_valid, if0.first,
                                if0.last, if0.done, if0.busy}), 32'(exp_vec(0)));
        check("outs_gap0", 32'({if1.s_ready, if1.sout, if1.sout_valid, if1.first,
                                if1.last, if1.done, if1.busy}), 32'(exp_vec(1)));
        // Scoreboard: rebuild words from the gap-1 serial stream.
        if (if0.sout_valid) begin
            rx_acc = {rx_acc[W-2:0], if0.sout};
            if (if0.last) begin
                if (exp_q.size() == 0)
                    check("sb_unexpected_word", 32'(rx_acc), 32'hFFFF_FFFF);
                else
                    check("sb_word", 32'(rx_acc), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Offer a word and hold it valid until the gap-1 instance takes it (bounded).
    task automatic send_word(input logic [W-1:0] d);
        int tries;
        tries = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, d);
            tries++;
        end while (!acc0 && tries < 16);
        check("send_accepted", 32'(acc0), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hv[k] = 1'b0; cv[k] = 1'b0; cs[k] = 0; pdone[k] = -1;
            hd[k] = '0;   cd[k] = '0;
        end
        rx_acc = '0;

        // Reset held for two edges while a word is offered: nothing is accepted.
        step(1'b0, 1'b0, 1'b1, 4'b1010);
        step(1'b0, 1'b0, 1'b1, 4'b1010);
        check("rst_s_ready", 32'(if0.s_ready), 32'd1);
        check("rst_sout_valid", 32'(if0.sout_valid), 32'd0);
        check("rst_busy", 32'(if0.busy), 32'd0);
        idle(2);
        check("rst_no_accept_busy", 32'(if0.busy), 32'd0);

        // Single word.
        send_word(4'b0110);
        idle(8);

        // Back-to-back words, second one refilling hold during the first shift.
        send_word(4'b1011);
        send_word(4'b0111);
        idle(12);

        // Word boundary pair (contiguous on the gap-0 instance).
        send_word(4'b1000);
        send_word(4'b0001);
        idle(12);

        // Flush on the 2nd bit of 4'b1111 with the hold full; the offer on the
        // flush edge must be dropped.
        send_word(4'b1111);
        send_word(4'b1010);
        check("pre_flush_hold_full", 32'(if0.s_ready), 32'd0);
        step(1'b1, 1'b1, 1'b1, 4'b0011);
        check("flush_sout_valid", 32'(if0.sout_valid), 32'd0);
        check("flush_s_ready", 32'(if0.s_ready), 32'd1);
        check("flush_busy", 32'(if0.busy), 32'd0);
        idle(2);
        send_word(4'b0101);
        idle(8);

        // Reset in the middle of 4'b1100 (on its 3rd bit).
        send_word(4'b1100);
        idle(3);
        step(1'b0, 1'b0, 1'b0, '0);
        check("midrst_outs", 32'({if0.sout, if0.sout_valid, if0.first, if0.last,
                                  if0.done, if0.busy}), 32'd0);
        check("midrst_s_ready", 32'(if0.s_ready), 32'd1);
        idle(8);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 99) < 65),
                 W'($urandom_range(0, 15)));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
